regfile_wb: RTL and testbench

Integer register file plus a one-entry writeback stage for the RV32I core.
- Accepts ALU results (destination index + data), holds them one cycle in a writeback register, then commits them to the 32x32 array.
- Supplies rs1/rs2 operand data to the ALU, with bypass from the pending writeback entry so dependent instructions see the newest value.
- Sits between execute (result producer) and decode/operand fetch (rs1/rs2 consumer).

---
 rtl/regfile_wb_pkg.sv | 20 ++
 rtl/regfile_array.sv | 46 ++++
 rtl/regfile_wb.sv | 90 +++++++++
 tb/tb_regfile_wb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared constants and writeback request type for the integer register file
// Contents:
//   XLEN, NREG, REG_AW : data width, register count, register index width
//   REG_ZERO           : index of the hardwired-zero register x0
//   wb_req_t           : writeback request {valid, rd, data}, shared by execute and load units
package regfile_wb_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/regfile_array.sv
// rtl/regfile_array.sv - 32x32 flop-based register array, one write port, three read ports
// Ports:
//   clk, rst               : clock, asynchronous active-high clear of every entry
//   i_we, i_waddr, i_wdata : synchronous write port (writes to x0 are ignored)
//   i_raddr_a/b/c          : combinational read addresses
//   o_rdata_a/b/c          : read data, x0 always reads 0
module regfile_array
    import regfile_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    input  logic [REG_AW-1:0] i_raddr_c,
    output logic [XLEN-1:0]   o_rdata_a,
    output logic [XLEN-1:0]   o_rdata_b,
    output logic [XLEN-1:0]   o_rdata_c
);

    logic [NREG-1:0][XLEN-1:0] mem_q;
    logic [NREG-1:0][XLEN-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (i_we && (i_waddr != REG_ZERO)) begin
            mem_d[i_waddr] = i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // x0 is forced to zero at the read side as well, so the entry itself never matters.
    assign o_rdata_a = (i_raddr_a == REG_ZERO) ? '0 : mem_q[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == REG_ZERO) ? '0 : mem_q[i_raddr_b];
    assign o_rdata_c = (i_raddr_c == REG_ZERO) ? '0 : mem_q[i_raddr_c];

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - RV32I register file with one-entry writeback stage and operand bypass
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   i_wb_valid, i_wb_rd, i_wb_data  : writeback request from execute
//   i_stall                         : freeze stage register and array
//   i_rs1_addr/o_rs1_data           : operand 1 read (bypassed from pending entry)
//   i_rs2_addr/o_rs2_data           : operand 2 read (bypassed from pending entry)
//   i_dbg_addr/o_dbg_data           : debug read of the array only, no bypass
//   o_pending, o_pending_rd         : stage register holds an uncommitted entry, and its index
module regfile_wb
    import regfile_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_valid,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_stall,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    output logic [XLEN-1:0]   o_rs1_data,
    output logic [XLEN-1:0]   o_rs2_data,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [XLEN-1:0]   o_dbg_data,
    output logic              o_pending,
    output logic [REG_AW-1:0] o_pending_rd
);

    wb_req_t stage_q;
    wb_req_t stage_d;

    logic            commit_we;
    logic [XLEN-1:0] arr_rs1_data;
    logic [XLEN-1:0] arr_rs2_data;

    // Capture and commit share the same edge: the old entry goes to the array
    // while the new request replaces it. Writes to x0 never become pending.
    always_comb begin
        stage_d = stage_q;
        if (!i_stall) begin
            stage_d.valid = i_wb_valid && (i_wb_rd != REG_ZERO);
            stage_d.rd    = i_wb_rd;
            stage_d.data  = i_wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign commit_we = stage_q.valid && !i_stall;

    regfile_array u_array (
        .clk       (clk),
        .rst       (rst),
        .i_we      (commit_we),
        .i_waddr   (stage_q.rd),
        .i_wdata   (stage_q.data),
        .i_raddr_a (i_rs1_addr),
        .i_raddr_b (i_rs2_addr),
        .i_raddr_c (i_dbg_addr),
        .o_rdata_a (arr_rs1_data),
        .o_rdata_b (arr_rs2_data),
        .o_rdata_c (o_dbg_data)
    );

    function automatic logic [XLEN-1:0] bypass(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   arr_data,
        input wb_req_t           stage
    );
        if (addr == REG_ZERO) begin
            return '0;
        end else if (stage.valid && (stage.rd == addr)) begin
            return stage.data;
        end else begin
            return arr_data;
        end
    endfunction

    assign o_rs1_data   = bypass(i_rs1_addr, arr_rs1_data, stage_q);
    assign o_rs2_data   = bypass(i_rs2_addr, arr_rs2_data, stage_q);
    assign o_pending    = stage_q.valid;
    assign o_pending_rd = stage_q.valid ? stage_q.rd : REG_ZERO;

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - self-checking bench for regfile_wb
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        i_stall;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic [4:0]  i_dbg_addr;
    logic [31:0] o_dbg_data;
    logic        o_pending;
    logic [4:0]  o_pending_rd;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem[32];

    regfile_wb dut (
        .clk          (clk),
        .rst          (rst),
        .i_wb_valid   (i_wb_valid),
        .i_wb_rd      (i_wb_rd),
        .i_wb_data    (i_wb_data),
        .i_stall      (i_stall),
        .i_rs1_addr   (i_rs1_addr),
        .i_rs2_addr   (i_rs2_addr),
        .o_rs1_data   (o_rs1_data),
        .o_rs2_data   (o_rs2_data),
        .i_dbg_addr   (i_dbg_addr),
        .o_dbg_data   (o_dbg_data),
        .o_pending    (o_pending),
        .o_pending_rd (o_pending_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed=%h but no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        i_rs1_addr = a1;
        i_rs2_addr = a2;
        i_dbg_addr = ad;
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_wb_valid = v;
        i_wb_rd    = rd;
        i_wb_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        i_stall = 1'b0;
        i_rs1_addr = 5'd0;
        i_rs2_addr = 5'd0;
        i_dbg_addr = 5'd0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        #12;
        rst = 1'b0;

        // Reset state
        push(32'h0); push(32'h0); push(32'h0); push(32'h0);
        set_rd(5'd5, 5'd31, 5'd5);
        chk("reset_pending", {31'h0, o_pending});
        chk("reset_pending_rd", {27'h0, o_pending_rd});
        chk("reset_rs1", o_rs1_data);
        chk("reset_dbg", o_dbg_data);

        // Commit x5, leave x6 in flight, then reset mid-cycle
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wb(1'b1, 5'd6, 32'hCAFEF00D);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        push(32'hDEADBEEF); push(32'h1); push(32'd6); push(32'hCAFEF00D);
        set_rd(5'd5, 5'd6, 5'd5);
        chk("pre_reset_dbg_x5", o_dbg_data);
        chk("pre_reset_pending", {31'h0, o_pending});
        chk("pre_reset_pending_rd", {27'h0, o_pending_rd});
        chk("pre_reset_rs2_x6", o_rs2_data);
        rst = 1'b1;
        #1;
        push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
        chk("async_reset_rs1_x5", o_rs1_data);
        chk("async_reset_rs2_x6", o_rs2_data);
        chk("async_reset_dbg_x5", o_dbg_data);
        chk("async_reset_pending", {31'h0, o_pending});
        chk("async_reset_pending_rd", {27'h0, o_pending_rd});
        #1;
        rst = 1'b0;

        // Latency
        wb(1'b1, 5'd3, 32'h12345678);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        push(32'h12345678); push(32'h0); push(32'h1); push(32'd3);
        set_rd(5'd3, 5'd0, 5'd3);
        chk("lat_n_rs1", o_rs1_data);
        chk("lat_n_dbg", o_dbg_data);
        chk("lat_n_pending", {31'h0, o_pending});
        chk("lat_n_pending_rd", {27'h0, o_pending_rd});
        tick();
        push(32'h12345678); push(32'h0); push(32'h12345678); push(32'h0);
        chk("lat_n1_dbg", o_dbg_data);
        chk("lat_n1_pending", {31'h0, o_pending});
        chk("lat_n1_rs1", o_rs1_data);
        chk("lat_n1_pending_rd", {27'h0, o_pending_rd});
        ref_mem[3] = 32'h12345678;

        // Back-to-back writes to the same rd
        wb(1'b1, 5'd7, 32'h11);
        tick();
        wb(1'b1, 5'd7, 32'h22);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        push(32'h22); push(32'h11);
        set_rd(5'd0, 5'd7, 5'd7);
        chk("b2b_n1_rs2", o_rs2_data);
        chk("b2b_n1_dbg", o_dbg_data);
        tick();
        push(32'h22); push(32'h22);
        chk("b2b_n2_dbg", o_dbg_data);
        chk("b2b_n2_rs2", o_rs2_data);
        ref_mem[7] = 32'h22;

        // Writes to x0 are dropped
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(5'd0, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            push(32'h0); push(32'h0); push(32'h0); push(32'h0);
            chk("x0_pending", {31'h0, o_pending});
            chk("x0_pending_rd", {27'h0, o_pending_rd});
            chk("x0_rs1", o_rs1_data);
            chk("x0_dbg", o_dbg_data);
        end

        // Stall holds the pending entry and ignores new input
        wb(1'b1, 5'd9, 32'hA5A5A5A5);
        tick();
        wb(1'b1, 5'd10, 32'h0BADBAD0);
        i_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            push(32'h1); push(32'd9); push(32'hA5A5A5A5); push(32'h0); push(32'h0);
            set_rd(5'd9, 5'd10, 5'd9);
            chk("stall_pending", {31'h0, o_pending});
            chk("stall_pending_rd", {27'h0, o_pending_rd});
            chk("stall_rs1_x9", o_rs1_data);
            chk("stall_dbg_x9", o_dbg_data);
            chk("stall_rs2_x10", o_rs2_data);
        end
        push(32'hA5A5A5A5); push(32'hA5A5A5A5);
        set_rd(5'd9, 5'd9, 5'd10);
        chk("dual_rs1_x9", o_rs1_data);
        chk("dual_rs2_x9", o_rs2_data);
        push(32'h0);
        chk("stall_dbg_x10", o_dbg_data);
        i_stall = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        tick();
        push(32'hA5A5A5A5); push(32'h0); push(32'h0);
        set_rd(5'd0, 5'd10, 5'd9);
        chk("unstall_dbg_x9", o_dbg_data);
        chk("unstall_pending", {31'h0, o_pending});
        chk("unstall_rs2_x10", o_rs2_data);
        ref_mem[9] = 32'hA5A5A5A5;

        // Streamed writes to assorted registers, bypass then array contents
        for (int k = 0; k < 10; k++) begin
            logic [4:0]  r;
            logic [31:0] d;
            r = 5'($urandom_range(1, 31));
            d = $urandom();
            wb(1'b1, r, d);
            tick();
            ref_mem[r] = d;
            push(d);
            set_rd(r, 5'd0, 5'd0);
            chk("stream_bypass", o_rs1_data);
        end
        wb(1'b0, 5'd0, 32'h0);
        tick();
        for (int a = 0; a < 32; a++) begin
            push(ref_mem[a]);
            push(ref_mem[a]);
            set_rd(5'(a), 5'd0, 5'(a));
            chk("final_dbg", o_dbg_data);
            chk("final_rs1", o_rs1_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
